regfile_dump_reader: RTL
========================

REGFILE_DUMP_READER -- requirements
Module: regfile_dump_reader

Interface
REQ-001 SHALL have a single clock `clock`; `reset` is synchronous and active-high.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous active-high reset
- start  in  1  request a dump; sampled only in IDLE
- first_reg  in  4  first register index of the dump
- num_regs  in  5  register count, 0..16
- rf_addr1  out  4  register-file read address, port 1
- rf_addr2  out  4  register-file read address, port 2
- rf_rdata1  in  16  register-file read data, port 1 (combinational in rf_addr1)
- rf_rdata2  in  16  register-file read data, port 2 (combinational in rf_addr2)
- out_valid  out  1  stream word valid
- out_ready  in  1  stream consumer ready
- out_data  out  16  register value
- out_addr  out  4  register index of out_data
- out_last  out  1  final word of the dump
- busy  out  1  dump in progress
- done  out  1  one-cycle completion pulse
- checksum  out  16  running mod-2^16 sum of emitted words

Function
REQ-003 FSM states SHALL be IDLE, FETCH and DRAIN.
REQ-004 IDLE to FETCH SHALL occur on start=1 with num_regs in 1..16; first_reg and num_regs are latched, checksum cleared, busy=1 from the next cycle.
REQ-005 start=1 with num_regs=0 SHALL stay in IDLE, clear checksum, pulse done the next cycle, and produce no out_valid.
REQ-006 start SHALL be ignored while busy=1.
REQ-007 In FETCH, rf_addr1 SHALL drive the next address a and rf_addr2 SHALL drive a+1 mod 16; addresses wrap 15 to 0.
REQ-008 A 2-entry buffer SHALL capture both read words as a pair (one word if one register remains) when the occupancy is 0, or 1 with a pop in the same cycle.
REQ-009 The read pointer SHALL advance by the number of words captured.
REQ-010 A pop SHALL occur on out_valid and out_ready; the head word drives out_data and out_addr.
REQ-011 While out_valid=1 and out_ready=0, out_data, out_addr and out_last SHALL hold stable.
REQ-012 Sustained throughput SHALL be 1 word/cycle with out_ready=1.
REQ-013 Latency from the start cycle N SHALL be: FETCH in N+1, first out_valid in N+2.
REQ-014 After the last capture the FSM SHALL move from FETCH to DRAIN; DRAIN SHALL go to IDLE on the pop of the word with out_last=1.
REQ-015 done SHALL pulse one cycle after that pop, with busy=0 in the same cycle.
REQ-016 Words SHALL be emitted in address order first_reg, first_reg+1, ... mod 16, exactly num_regs words, no duplicates.
REQ-017 checksum SHALL add out_data on every pop, mod 2^16, and hold after done until the next accepted start.
REQ-018 rf_addr1 and rf_addr2 SHALL be don't-care outside FETCH and SHALL drive 0 there.

Reset
REQ-019 reset SHALL force IDLE, clear the buffer, and set out_valid, out_last, busy and done to 0 and checksum to 0x0000.
REQ-020 A reset mid-dump SHALL abort with no done pulse; reset has priority over start.

Structure
REQ-021 The shared package regfile_pkg SHALL hold REG_ADDR_W=4, DATA_W=16, NUM_REGS=16 and the FSM state enum.
REQ-022 The 2-entry skid buffer SHALL be the sub-module regfile_dump_buf (push 1 or 2 words, pop 1, count output).

Verification
Bench preloads reg i = 16'h1000+i.
REQ-023 first_reg=0, num_regs=16, out_ready=1 -> 1000..100F on 16 consecutive cycles, out_last on addr F, done next cycle, checksum=0x0078.
REQ-024 first_reg=E, num_regs=4 -> addresses E,F,0,1 with data 100E,100F,1000,1001; checksum=0x401E.
REQ-025 first_reg=3, num_regs=3 -> 1003,1004,1005; out_last on addr 5; exactly 3 pops.
REQ-026 num_regs=16, out_ready=0 for 3 cycles after word 4 -> word 4 held stable; stream resumes at 1005 with no loss or duplicate.
REQ-027 num_regs=0 -> done pulses 1 cycle after start, out_valid never 1, checksum=0x0000.
REQ-028 reset after 5 pops -> next cycle out_valid=0, busy=0, checksum=0x0000, no done; a new start then dumps normally.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file dump reader and its skid buffer.
package regfile_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 16;
    localparam int NUM_REGS   = 16;
    localparam int COUNT_W    = $clog2(NUM_REGS) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One buffered stream word: register index, its value, and end-of-dump flag.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
        logic                  last;
    } word_t;

endpackage

// File: rtl/regfile_dump_buf.sv
// Two-entry skid buffer: pushes one or two words per cycle, pops one from the head.
module regfile_dump_buf
    import regfile_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] push_n_i,
    input  word_t      push_w0_i,
    input  word_t      push_w1_i,
    input  logic       pop_i,
    output word_t      head_o,
    output logic [1:0] count_o
);

    word_t      e0_q, e0_d;
    word_t      e1_q, e1_d;
    logic [1:0] cnt_q, cnt_d;

    // Storage and occupancy register.
    always_ff @(posedge clock) begin
        if (reset) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    // Pop shifts the tail forward first, then new words append behind what remains.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (pop_i && cnt_q != 2'd0) begin
            e0_d  = e1_q;
            cnt_d = cnt_q - 2'd1;
        end
        if (push_n_i != 2'd0) begin
            if (cnt_d == 2'd0) begin
                e0_d  = push_w0_i;
                e1_d  = push_w1_i;
                cnt_d = push_n_i;
            end else if (cnt_d == 2'd1) begin
                e1_d  = push_w0_i;
                cnt_d = 2'd2;
            end
        end
    end

    assign head_o  = e0_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Streams a contiguous (wrapping) range of register-file entries, two reads per cycle.
//
//   state | meaning
//   IDLE  | waiting for start; num_regs=0 completes immediately
//   FETCH | reading pairs into the skid buffer until all registers captured
//   DRAIN | all captured; emptying buffer until the last word pops
module regfile_dump_reader
    import regfile_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [REG_ADDR_W-1:0] first_reg,
    input  logic [COUNT_W-1:0]    num_regs,
    output logic [REG_ADDR_W-1:0] rf_addr1,
    output logic [REG_ADDR_W-1:0] rf_addr2,
    input  logic [DATA_W-1:0]     rf_rdata1,
    input  logic [DATA_W-1:0]     rf_rdata2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [REG_ADDR_W-1:0] out_addr,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     checksum
);

    state_t                state_q, state_d;
    logic [REG_ADDR_W-1:0] ptr_q, ptr_d;
    logic [COUNT_W-1:0]    remain_q, remain_d;
    logic [DATA_W-1:0]     checksum_q, checksum_d;
    logic                  done_q, done_d;

    logic [1:0]            push_n;
    logic [1:0]            buf_count;
    logic                  pop;
    logic [REG_ADDR_W-1:0] ptr_p1;
    word_t                 head;
    word_t                 push_w0;
    word_t                 push_w1;

    assign ptr_p1  = ptr_q + 4'd1;
    assign push_w0 = '{addr: ptr_q,  data: rf_rdata1, last: (remain_q == 5'd1)};
    assign push_w1 = '{addr: ptr_p1, data: rf_rdata2, last: (remain_q == 5'd2)};
    assign pop     = out_valid & out_ready;

    regfile_dump_buf u_buf (
        .clock     (clock),
        .reset     (reset),
        .push_n_i  (push_n),
        .push_w0_i (push_w0),
        .push_w1_i (push_w1),
        .pop_i     (pop),
        .head_o    (head),
        .count_o   (buf_count)
    );

    // FSM state, read pointer, remaining count, checksum and done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            remain_q   <= '0;
            checksum_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            remain_q   <= remain_d;
            checksum_q <= checksum_d;
            done_q     <= done_d;
        end
    end

    // Next-state, capture decision and read-address drive.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        remain_d   = remain_q;
        checksum_d = checksum_q;
        done_d     = 1'b0;
        push_n     = 2'd0;
        rf_addr1   = '0;
        rf_addr2   = '0;
        if (pop) begin
            checksum_d = checksum_q + head.data;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    checksum_d = '0;
                    if (num_regs == 5'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = FETCH;
                        ptr_d    = first_reg;
                        remain_d = num_regs;
                    end
                end
            end
            FETCH: begin
                rf_addr1 = ptr_q;
                rf_addr2 = ptr_p1;
                // Capture only into an empty buffer, or one emptying this cycle.
                if (buf_count == 2'd0 || (buf_count == 2'd1 && pop)) begin
                    push_n   = (remain_q >= 5'd2) ? 2'd2 : 2'd1;
                    ptr_d    = ptr_q + {2'b00, push_n};
                    remain_d = remain_q - {3'b000, push_n};
                    if (remain_d == 5'd0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && head.last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = (buf_count != 2'd0);
    assign out_data  = head.data;
    assign out_addr  = head.addr;
    assign out_last  = out_valid & head.last;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign checksum  = checksum_q;

endmodule
